// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared types and constants for the 8-bit tristate peripheral
//               bus initiator: bus widths, command word layout, FSM states
//               and the default park address.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // One queued command: {we, addr, wdata} = 17 bits.
    localparam int CMD_W = 1 + ADDR_W + DATA_W;

    // Address held on the bus while idle; no peripheral decodes it.
    localparam logic [ADDR_W-1:0] PARK_ADDR_DEFAULT = 8'hFF;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_TURN    = 3'd4
    } state_t;

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bus_cmd_fifo
// Description : Synchronous show-ahead FIFO holding initiator commands.
//               The head entry is always visible on dout_o; pop_i consumes it.
//               A push while full is dropped, even if a pop happens in the
//               same cycle.
// Ports       : clk_i    - clock
//               rst_i    - synchronous active-high reset (flushes FIFO)
//               push_i   - write din_i (ignored when full)
//               din_i    - entry to write
//               pop_i    - consume head entry (ignored when empty)
//               dout_o   - head entry
//               full_o   - DEPTH entries stored
//               empty_o  - no entries stored
// Revision    : 1.0 - initial release
// ============================================================================
module bus_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    assign dout_o = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read behind a valid pointer.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
        end
    end

endmodule : bus_cmd_fifo
`default_nettype wire

// File: rtl/bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : bus_initiator
// Description : Processor-side master for the shared 8-bit tristate
//               peripheral bus. Requests are queued in a command FIFO,
//               sequenced onto the bus one at a time and completed with a
//               single-cycle response pulse. The bus data lines are driven
//               only during a write cycle; otherwise the bus is parked at
//               PARK_ADDR with BUS_WE low and BUS_DATA released.
//               Responders register their read-enable, so read data appears
//               one cycle after the address; every read ends with a TURN
//               cycle so the responder can release BUS_DATA before the
//               next write drives it.
// Option      : `BUS_INIT_TXN_COUNT_EN builds 16-bit wrapping counters of
//               completed reads/writes on RD_COUNT/WR_COUNT; otherwise both
//               outputs are tied to zero.
// Ports       : CLK, RESET (sync, active high)
//               REQ_VALID/REQ_READY/REQ_WE/REQ_ADDR/REQ_WDATA - request in
//               RSP_VALID/RSP_WE/RSP_ADDR/RSP_RDATA           - completion
//               BUSY                - FIFO non-empty or FSM not idle
//               BUS_ADDR/BUS_WE/BUS_DATA - peripheral bus
//               RD_COUNT/WR_COUNT   - completed transaction counters
// Revision    : 1.0 - initial release
// ============================================================================
module bus_initiator
    import bus_pkg::*;
#(
    parameter int                FIFO_DEPTH = 4,
    parameter int                READ_WAIT  = 1,
    parameter logic [ADDR_W-1:0] PARK_ADDR  = PARK_ADDR_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              RSP_VALID,
    output logic              RSP_WE,
    output logic [ADDR_W-1:0] RSP_ADDR,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              BUSY,
    output logic [ADDR_W-1:0] BUS_ADDR,
    output logic              BUS_WE,
    inout  wire  [DATA_W-1:0] BUS_DATA,
    output logic [15:0]       RD_COUNT,
    output logic [15:0]       WR_COUNT
);

    // RD_DATA lasts READ_WAIT cycles; the counter runs 0..READ_WAIT-1.
    localparam int                WAIT_W      = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(READ_WAIT - 1);

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t w_req_cmd;
    cmd_t w_head_cmd;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    state_t state_q;

    assign w_req_cmd = {REQ_WE, REQ_ADDR, REQ_WDATA};
    assign REQ_READY = !w_full;
    assign w_push    = REQ_VALID && !w_full;

    // A new command can only be launched from the idle, write or
    // turnaround slots; reads hold the bus for their full sequence.
    assign w_pop = !w_empty &&
                   ((state_q == ST_IDLE) || (state_q == ST_WR) || (state_q == ST_TURN));

    bus_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .push_i  (w_push),
        .din_i   (w_req_cmd),
        .pop_i   (w_pop),
        .dout_o  (w_head_cmd),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM with registered bus and response outputs
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] bus_addr_q;
    logic              bus_we_q;
    logic [DATA_W-1:0] bus_wdata_q;
    logic [WAIT_W-1:0] wait_q;
    logic              rsp_valid_q;
    logic              rsp_we_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            bus_addr_q  <= PARK_ADDR;
            bus_we_q    <= 1'b0;
            bus_wdata_q <= '0;
            wait_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;

            unique case (state_q)
                ST_RD_ADDR: begin
                    state_q <= ST_RD_DATA;
                    wait_q  <= '0;
                end

                ST_RD_DATA: begin
                    if (wait_q == c_wait_last) begin
                        // Responder data has been on the bus for a full
                        // cycle by this edge: capture and complete.
                        rsp_valid_q <= 1'b1;
                        rsp_we_q    <= 1'b0;
                        rsp_addr_q  <= bus_addr_q;
                        rsp_rdata_q <= BUS_DATA;
                        state_q     <= ST_TURN;
                        bus_addr_q  <= PARK_ADDR;
                        bus_we_q    <= 1'b0;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end

                // IDLE, WR and TURN all act as dispatch slots.
                default: begin
                    if (state_q == ST_WR) begin
                        rsp_valid_q <= 1'b1;
                        rsp_we_q    <= 1'b1;
                        rsp_addr_q  <= bus_addr_q;
                        rsp_rdata_q <= '0;
                    end

                    if (w_pop) begin
                        state_q     <= w_head_cmd.we ? ST_WR : ST_RD_ADDR;
                        bus_addr_q  <= w_head_cmd.addr;
                        bus_we_q    <= w_head_cmd.we;
                        bus_wdata_q <= w_head_cmd.wdata;
                    end else begin
                        state_q    <= ST_IDLE;
                        bus_addr_q <= PARK_ADDR;
                        bus_we_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // BUS_WE is high only in WR, so it doubles as the data output enable.
    assign BUS_ADDR = bus_addr_q;
    assign BUS_WE   = bus_we_q;
    assign BUS_DATA = bus_we_q ? bus_wdata_q : {DATA_W{1'bz}};

    assign RSP_VALID = rsp_valid_q;
    assign RSP_WE    = rsp_we_q;
    assign RSP_ADDR  = rsp_addr_q;
    assign RSP_RDATA = rsp_rdata_q;

    assign BUSY = !w_empty || (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // Optional completed-transaction counters
    // ------------------------------------------------------------------
`ifdef BUS_INIT_TXN_COUNT_EN
    logic [15:0] rd_count_q;
    logic [15:0] wr_count_q;

    // Counters follow the response pulse; natural 16-bit wrap.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_count_q <= 16'h0000;
            wr_count_q <= 16'h0000;
        end else if (rsp_valid_q) begin
            if (rsp_we_q) begin
                wr_count_q <= wr_count_q + 16'd1;
            end else begin
                rd_count_q <= rd_count_q + 16'd1;
            end
        end
    end

    assign RD_COUNT = rd_count_q;
    assign WR_COUNT = wr_count_q;
`else
    assign RD_COUNT = 16'h0000;
    assign WR_COUNT = 16'h0000;
`endif

endmodule : bus_initiator
`default_nettype wire

// File: tb/tb_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_initiator
// Description : Directed self-checking bench for bus_initiator. Contains a
//               registered responder at D0/D1 (read-enable flop, data driven
//               one cycle after the address) and a pull-up on BUS_DATA so a
//               released bus reads 8'hFF.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_initiator;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_we;
    logic [7:0] rsp_addr;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic [7:0] bus_addr;
    logic       bus_we;
    tri1  [7:0] bus_data;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    always #5 clk = ~clk;

    bus_initiator #(
        .FIFO_DEPTH (4),
        .READ_WAIT  (1),
        .PARK_ADDR  (8'hFF)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .REQ_VALID (req_valid),
        .REQ_READY (req_ready),
        .REQ_WE    (req_we),
        .REQ_ADDR  (req_addr),
        .REQ_WDATA (req_wdata),
        .RSP_VALID (rsp_valid),
        .RSP_WE    (rsp_we),
        .RSP_ADDR  (rsp_addr),
        .RSP_RDATA (rsp_rdata),
        .BUSY      (busy),
        .BUS_ADDR  (bus_addr),
        .BUS_WE    (bus_we),
        .BUS_DATA  (bus_data),
        .RD_COUNT  (rd_count),
        .WR_COUNT  (wr_count)
    );

    // ---------------- responder model ----------------
    logic [7:0] mem_d0 = 8'h00;
    logic [7:0] mem_d1 = 8'hA5;
    logic       rsp_en_q = 1'b0;
    logic [7:0] rsp_sel_q = 8'h00;

    always @(posedge clk) begin
        rsp_en_q  <= !bus_we && (bus_addr == 8'hD0 || bus_addr == 8'hD1);
        rsp_sel_q <= bus_addr;
        if (bus_we && bus_addr == 8'hD0) mem_d0 <= bus_data;
        if (bus_we && bus_addr == 8'hD1) mem_d1 <= bus_data;
    end

    assign bus_data = rsp_en_q ? ((rsp_sel_q == 8'hD0) ? mem_d0 : mem_d1) : 8'hzz;

    // ---------------- monitors ----------------
    int         cyc = 0;
    int         rsp_cnt = 0;
    int         contention = 0;
    logic [7:0] wr_seen[$];
    int         wr_cyc[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus_we) begin
            wr_seen.push_back(bus_data);
            wr_cyc.push_back(cyc);
        end
        if (rsp_valid) rsp_cnt = rsp_cnt + 1;
        if (rsp_en_q && bus_we) contention = contention + 1;
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic saw_not_ready = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a request and keep REQ_VALID high until it is accepted.
    task automatic push(input logic we, input logic [7:0] a, input logic [7:0] d);
        logic acc;
        logic done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 50 && !done; i++) begin
            acc = req_ready;
            if (!acc) saw_not_ready = 1'b1;
            step(1);
            if (acc) done = 1'b1;
        end
        if (!done) check("push_accept", 16'(done), 16'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) step(1);
        check("wait_idle", 16'(busy), 16'd0);
    endtask

    int rsp_base;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;

        // ---- 1. reset state ----
        step(3);
        check("rst_bus_addr", 16'(bus_addr), 16'hFF);
        check("rst_bus_we", 16'(bus_we), 16'd0);
        check("rst_bus_data_released", 16'(bus_data), 16'hFF);
        check("rst_req_ready", 16'(req_ready), 16'd1);
        check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        check("rst_rsp_addr", 16'(rsp_addr), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_rd_count", rd_count, 16'd0);
        check("rst_wr_count", wr_count, 16'd0);
        rst = 1'b0;
        step(1);

        // ---- 2. single write D0 <= 3C ----
        wr_seen.delete();
        wr_cyc.delete();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'hD0; req_wdata = 8'h3C;
        step(1);                                   // edge T
        req_valid = 1'b0;
        check("wr_t1_bus_we", 16'(bus_we), 16'd0);
        check("wr_t1_busy", 16'(busy), 16'd1);
        step(1);                                   // cycle T+2
        check("wr_t2_bus_addr", 16'(bus_addr), 16'hD0);
        check("wr_t2_bus_we", 16'(bus_we), 16'd1);
        check("wr_t2_bus_data", 16'(bus_data), 16'h3C);
        check("wr_t2_rsp_valid", 16'(rsp_valid), 16'd0);
        step(1);                                   // cycle T+3
        check("wr_t3_rsp_valid", 16'(rsp_valid), 16'd1);
        check("wr_t3_rsp_we", 16'(rsp_we), 16'd1);
        check("wr_t3_rsp_addr", 16'(rsp_addr), 16'hD0);
        check("wr_t3_rsp_rdata", 16'(rsp_rdata), 16'h00);
        check("wr_t3_bus_parked", 16'(bus_addr), 16'hFF);
        check("wr_t3_bus_we", 16'(bus_we), 16'd0);
        check("wr_model_d0", 16'(mem_d0), 16'h3C);
        step(1);
        check("wr_t4_rsp_valid", 16'(rsp_valid), 16'd0);
        check("wr_t4_rsp_addr_held", 16'(rsp_addr), 16'hD0);
        check("wr_t4_busy", 16'(busy), 16'd0);
        check("wr_one_bus_cycle", 16'(wr_seen.size()), 16'd1);

        // ---- 3. read D1 (A5) ----
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hD1; req_wdata = 8'h00;
        step(1);                                   // edge T
        req_valid = 1'b0;
        step(1);                                   // T+2 RD_ADDR
        check("rd_t2_bus_addr", 16'(bus_addr), 16'hD1);
        check("rd_t2_bus_we", 16'(bus_we), 16'd0);
        check("rd_t2_bus_data", 16'(bus_data), 16'hFF);
        step(1);                                   // T+3 RD_DATA
        check("rd_t3_bus_addr", 16'(bus_addr), 16'hD1);
        check("rd_t3_bus_data", 16'(bus_data), 16'hA5);
        check("rd_t3_rsp_valid", 16'(rsp_valid), 16'd0);
        step(1);                                   // T+4 TURN + response
        check("rd_t4_rsp_valid", 16'(rsp_valid), 16'd1);
        check("rd_t4_rsp_we", 16'(rsp_we), 16'd0);
        check("rd_t4_rsp_addr", 16'(rsp_addr), 16'hD1);
        check("rd_t4_rsp_rdata", 16'(rsp_rdata), 16'hA5);
        check("rd_t4_bus_parked", 16'(bus_addr), 16'hFF);
        step(1);
        check("rd_t5_rsp_valid", 16'(rsp_valid), 16'd0);
        check("rd_t5_busy", 16'(busy), 16'd0);
        check("rd_no_write_cycle", 16'(wr_seen.size()), 16'd1);

        // ---- 4. two reads stall the bus, then six held writes fill FIFO ----
        wr_seen.delete();
        wr_cyc.delete();
        rsp_base      = rsp_cnt;
        saw_not_ready = 1'b0;
        push(1'b0, 8'hD1, 8'h00);
        push(1'b0, 8'hD1, 8'h00);
        for (int k = 1; k <= 6; k++) push(1'b1, 8'hD0, 8'(k));
        req_valid = 1'b0;
        wait_idle();
        step(2);
        check("fill_ready_dropped", 16'(saw_not_ready), 16'd1);
        check("fill_write_count", 16'(wr_seen.size()), 16'd6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("fill_order_%0d", k), 16'(wr_seen[k]), 16'(k + 1));
            check($sformatf("fill_consec_%0d", k), 16'(wr_cyc[k] - wr_cyc[0]), 16'(k));
        end
        check("fill_rsp_count", 16'(rsp_cnt - rsp_base), 16'd8);
        check("fill_model_d0", 16'(mem_d0), 16'h06);

        // ---- 5. read D1 then write D0 <= 77: turnaround before write ----
        wr_seen.delete();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hD1; req_wdata = 8'h00;
        step(1);                                   // read accepted
        req_we = 1'b1; req_addr = 8'hD0; req_wdata = 8'h77;
        step(1);                                   // write accepted, RD_ADDR
        req_valid = 1'b0;
        step(1);                                   // RD_DATA
        check("turn_rd_data", 16'(bus_data), 16'hA5);
        step(1);                                   // TURN
        check("turn_bus_addr", 16'(bus_addr), 16'hFF);
        check("turn_bus_we", 16'(bus_we), 16'd0);
        check("turn_responder_still_driving", 16'(bus_data), 16'hA5);
        check("turn_rsp_rdata", 16'(rsp_rdata), 16'hA5);
        step(1);                                   // WR
        check("turn_wr_bus_addr", 16'(bus_addr), 16'hD0);
        check("turn_wr_bus_we", 16'(bus_we), 16'd1);
        check("turn_wr_bus_data", 16'(bus_data), 16'h77);
        step(2);
        check("turn_model_d0", 16'(mem_d0), 16'h77);
        check("no_bus_contention", 16'(contention), 16'd0);

        // ---- 6. reset while in RD_DATA with writes queued ----
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hD1; req_wdata = 8'h00;
        step(1);
        req_we = 1'b1; req_addr = 8'hD0; req_wdata = 8'h11;
        step(1);
        req_wdata = 8'h22;
        step(1);
        req_valid = 1'b0;
        check("rstmid_in_read", 16'(bus_addr), 16'hD1);
        wr_seen.delete();
        rsp_base = rsp_cnt;
        rst = 1'b1;
        step(1);
        check("rstmid_rsp_valid", 16'(rsp_valid), 16'd0);
        check("rstmid_busy", 16'(busy), 16'd0);
        check("rstmid_bus_addr", 16'(bus_addr), 16'hFF);
        check("rstmid_bus_we", 16'(bus_we), 16'd0);
        check("rstmid_req_ready", 16'(req_ready), 16'd1);
        rst = 1'b0;
        step(6);
        check("rstmid_no_rsp", 16'(rsp_cnt - rsp_base), 16'd0);
        check("rstmid_queue_dropped", 16'(wr_seen.size()), 16'd0);
        check("rstmid_model_d0", 16'(mem_d0), 16'h77);
        check("rstmid_busy_after", 16'(busy), 16'd0);

        // ---- 7. transaction counters: 3 reads, 2 writes ----
        rsp_base = rsp_cnt;
        push(1'b0, 8'hD1, 8'h00);
        push(1'b0, 8'hD0, 8'h00);
        push(1'b0, 8'hD1, 8'h00);
        push(1'b1, 8'hD0, 8'h12);
        push(1'b1, 8'hD0, 8'h34);
        req_valid = 1'b0;
        wait_idle();
        step(2);
        check("cnt_rsp_total", 16'(rsp_cnt - rsp_base), 16'd5);
        check("cnt_model_d0", 16'(mem_d0), 16'h34);
`ifdef BUS_INIT_TXN_COUNT_EN
        check("cnt_rd_count", rd_count, 16'd3);
        check("cnt_wr_count", wr_count, 16'd2);
`else
        check("cnt_rd_count", rd_count, 16'd0);
        check("cnt_wr_count", wr_count, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_bus_initiator
`default_nettype wire
